// File: rtl/i2c_master_byte.sv
// Single-byte I2C bus master: START, address+R/W, one data byte, STOP.
// Drives open-drain enables for SCL/SDA; all outputs are registered.
module i2c_master_byte #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK,
        S_READ, S_RNACK, S_STOP, S_DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bitcnt;
    logic [7:0]    sh;
    logic [7:0]    dreg;
    logic [7:0]    rsh;
    logic          rw_q;
    logic          tick;
    logic          bit_end;
    logic          sample;
    logic          scl_oe_d;
    logic          sda_oe_d;
    logic          busy_d;
    logic          done_d;

    assign tick    = (qcnt == CW'(CLK_DIV - 1)) && (state != S_IDLE) && (state != S_DONE);
    assign bit_end = tick && (q == 2'd3);
    assign sample  = tick && (q == 2'd2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; every transition except IDLE/DONE waits for a quarter tick
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start && !done) state_next = S_START;
            S_START: if (tick && q == 2'd1) state_next = S_ADDR;
            S_ADDR:  if (bit_end && bitcnt == 3'd7) state_next = S_AACK;
            S_AACK:  if (bit_end) state_next = ack_err ? S_STOP : (rw_q ? S_READ : S_WRITE);
            S_WRITE: if (bit_end && bitcnt == 3'd7) state_next = S_WACK;
            S_WACK:  if (bit_end) state_next = S_STOP;
            S_READ:  if (bit_end && bitcnt == 3'd7) state_next = S_RNACK;
            S_RNACK: if (bit_end) state_next = S_STOP;
            S_STOP:  if (tick && q == 2'd2) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next output values, registered below
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        busy_d   = (state != S_IDLE) && (state != S_DONE);
        done_d   = (state == S_DONE);
        case (state)
            S_START: sda_oe_d = (q == 2'd1);
            S_ADDR: begin
                scl_oe_d = (q < 2'd2);
                sda_oe_d = !sh[7];
            end
            S_WRITE: begin
                scl_oe_d = (q < 2'd2);
                sda_oe_d = !dreg[7];
            end
            S_AACK, S_WACK, S_READ, S_RNACK: scl_oe_d = (q < 2'd2);
            S_STOP: begin
                scl_oe_d = (q == 2'd0);
                sda_oe_d = (q != 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            scl_oe <= scl_oe_d;
            sda_oe <= sda_oe_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    // Quarter timing, bit counting and shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt    <= '0;
            q       <= 2'd0;
            bitcnt  <= 3'd0;
            sh      <= 8'h00;
            dreg    <= 8'h00;
            rsh     <= 8'h00;
            rw_q    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            if ((state == S_IDLE) || (state == S_DONE) || tick) qcnt <= '0;
            else                                                 qcnt <= qcnt + CW'(1);

            if (state_next != state) begin
                q      <= 2'd0;
                bitcnt <= 3'd0;
            end else if (tick) begin
                q <= q + 2'd1;
                if (q == 2'd3) bitcnt <= bitcnt + 3'd1;
            end

            if (state == S_IDLE && state_next == S_START) begin
                sh      <= {addr, rw};
                dreg    <= wdata;
                rw_q    <= rw;
                ack_err <= 1'b0;
            end

            if (state == S_ADDR && bit_end)  sh   <= {sh[6:0], 1'b0};
            if (state == S_WRITE && bit_end) dreg <= {dreg[6:0], 1'b0};
            if (state == S_READ && sample)   rsh  <= {rsh[6:0], sda_i};
            if ((state == S_AACK || state == S_WACK) && sample && sda_i) ack_err <= 1'b1;
            if (state == S_READ && state_next == S_RNACK) rdata <= rsh;
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: behavioural I2C slave on the bus plus a
// scoreboard of expected transaction results checked at each done pulse.
module tb_i2c_master_byte;

    localparam int unsigned CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    logic slv_pull = 1'b0;
    logic scl_line;
    logic sda_line;

    assign scl_line = ~scl_oe;
    assign sda_i    = ~(sda_oe | slv_pull);
    assign sda_line = sda_i;

    i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
        .rdata(rdata), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] rdata;
        logic       ack_err;
        int         lat;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         rises;
        logic       rd;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    int t_acc = 0;
    int n_done = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave / bus monitor
    logic [7:0] rxq[$];
    logic [7:0] rx = 8'h00;
    logic [7:0] s_rd = 8'h00;
    logic       s_aack = 1'b1;
    logic       s_dack = 1'b1;
    logic       is_read = 1'b0;
    logic       sactive = 1'b0;
    logic       mnack = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         sbit = 0;
    int         sbyte = 0;
    int         starts = 0;
    int         stops = 0;
    int         rises = 0;

    always @(negedge clk) begin
        logic cs, cd;
        cs = scl_line;
        cd = sda_line;
        if (!rst_n) begin
            slv_pull = 1'b0;
            sactive  = 1'b0;
        end else if (prev_scl && cs && prev_sda && !cd) begin
            starts++;
            sbit = 0; sbyte = 0; mnack = 1'b0;
            rxq.delete();
            sactive = 1'b1;
            slv_pull = 1'b0;
        end else if (prev_scl && cs && !prev_sda && cd) begin
            stops++;
            sactive = 1'b0;
        end else if (!prev_scl && cs) begin
            rises++;
            if (sbit < 8) rx = {rx[6:0], cd};
            else if (sbit == 8 && sbyte == 1 && is_read) mnack = cd;
            sbit++;
        end else if (prev_scl && !cs && sactive) begin
            if (sbit == 9) begin
                sbit = 0;
                sbyte++;
            end
            if (sbit == 8) begin
                if (sbyte == 0) begin
                    rxq.push_back(rx);
                    is_read  = rx[0];
                    slv_pull = s_aack;
                    if (!s_aack) sactive = 1'b0;
                end else if (sbyte == 1 && !is_read) begin
                    rxq.push_back(rx);
                    slv_pull = s_dack;
                end else begin
                    slv_pull = 1'b0;
                end
            end else if (sbyte == 1 && is_read) begin
                slv_pull = !s_rd[7-sbit];
            end else begin
                slv_pull = 1'b0;
            end
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    // Scoreboard: pop and compare on each done pulse
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata",   32'(rdata), 32'(e.rdata));
                check("ack_err", 32'(ack_err), 32'(e.ack_err));
                check("latency", 32'(cyc - t_acc), 32'(e.lat));
                check("busy_at_done", 32'(busy), 32'd0);
                check("nbytes",  32'(rxq.size()), 32'(e.nbytes));
                if (rxq.size() > 0) check("byte0", 32'(rxq[0]), 32'(e.b0));
                if (e.nbytes > 1 && rxq.size() > 1) check("byte1", 32'(rxq[1]), 32'(e.b1));
                check("scl_rises", 32'(rises), 32'(e.rises));
                check("starts", 32'(starts), 32'd1);
                check("stops",  32'(stops), 32'd1);
                if (e.rd) check("master_nack", 32'(mnack), 32'd1);
            end
        end
    end

    logic [7:0] model_rdata = 8'h00;

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic [7:0] rd, input logic aack, input logic dack,
                           input logic mid_start);
        exp_t e;
        int   nd0;
        int   k;
        s_rd = rd; s_aack = aack; s_dack = dack;
        if (r && aack) model_rdata = rd;
        e.rdata   = model_rdata;
        e.ack_err = !aack || (!r && !dack);
        e.lat     = (aack ? 77 : 41) * int'(CLK_DIV) + 1;
        e.nbytes  = (aack && !r) ? 2 : 1;
        e.b0      = {a, r};
        e.b1      = wd;
        e.rises   = aack ? 19 : 10;
        e.rd      = r && aack;
        sb.push_back(e);
        starts = 0; stops = 0; rises = 0;
        nd0 = n_done;
        @(negedge clk);
        addr = a; rw = r; wdata = wd; start = 1'b1;
        t_acc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        if (mid_start) begin
            repeat (100) @(negedge clk);
            addr = 7'h7F; rw = ~r; wdata = ~wd; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (n_done == nd0 && k < 100 * int'(CLK_DIV) + 20) begin
            @(posedge clk);
            k++;
        end
        check("done_seen", 32'(n_done != nd0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_rdata",   32'(rdata), 32'h00);
        check("rst_scl_oe",  32'(scl_oe), 32'd0);
        check("rst_sda_oe",  32'(sda_oe), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0);
        run_txn(7'h50, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0);
        run_txn(7'h33, 1'b0, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ack_err_held", 32'(ack_err), 32'd1);
        check("rdata_held",   32'(rdata), 32'h3C);
        run_txn(7'h50, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0);
        run_txn(7'h50, 1'b0, 8'hC3, 8'h00, 1'b1, 1'b1, 1'b1);

        // Abort a write during data bit 3 with reset
        s_aack = 1'b1; s_dack = 1'b1;
        starts = 0; stops = 0; rises = 0;
        @(negedge clk);
        addr = 7'h50; rw = 1'b0; wdata = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(sbyte == 1 && sbit == 3 && scl_oe) && k < 1000) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        check("pre_rst_scl_low", 32'(scl_oe), 32'd1);
        check("pre_rst_sda_low", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_scl_oe", 32'(scl_oe), 32'd0);
        check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("mid_rst_busy",   32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check("post_rst_rdata", 32'(rdata), 32'h00);

        run_txn(7'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

Single-byte I2C bus master that generates the SCL/SDA traffic consumed by the team's I2C slave. A host-side pulse starts one complete transaction: START, 7-bit address plus R/W, one data byte (write or read), then STOP. The block reports slave acknowledge errors and returns read data. It sits between the system-clock control logic and the open-drain pad cells of the I2C bus.

## Interface
- CLK_DIV, default 250: system clocks per SCL quarter-period. SCL period is 4*CLK_DIV clocks. Legal range is CLK_DIV ≥ 2.
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; accepted only when busy=0.
- rw  in  1  0 = write wdata to the slave, 1 = read one byte from the slave.
- addr  in  7  target slave address.
- wdata  in  8  byte to write.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at transaction end.
- ack_err  out  1  set when the slave NACKs an address or write byte; held until the next accepted start.
- rdata  out  8  last byte read; updated only on read completion.
- scl_oe  out  1  1 = pull SCL low, 0 = release SCL.
- sda_oe  out  1  1 = pull SDA low, 0 = release SDA.
- sda_i  in  1  sampled SDA pad value, already synchronised externally.

## Operation
- Reset values: busy=0, done=0, ack_err=0, rdata=8'h00, scl_oe=0, sda_oe=0. State is IDLE, and both lines are released.
- Accepting start (in IDLE only):
  - Capture {addr,rw} into the shift register and wdata into the data register.
  - Clear ack_err.
  - Start the quarter counter.
  - start while busy is ignored; captured values are not disturbed.
- Quarter tick: a free counter runs 0..CLK_DIV-1 and ticks on wrap. The counter is held at 0 in IDLE. Every state below advances on ticks only.
- States:
  - IDLE: wait for start.
  - START (2 quarters):
    - q0: SCL released, SDA released.
    - q1: SCL released, SDA low.
  - ADDR (8 bits, MSB first): address bits then rw.
  - AACK (1 bit): SDA released, sample sda_i.
    - sda_i=1 → ack_err=1, go to STOP.
    - Otherwise go to WRITE if rw=0, READ if rw=1.
  - WRITE (8 bits, MSB first), then WACK (1 bit): SDA released, sample sda_i; sda_i=1 → ack_err=1. Go to STOP either way.
  - READ (8 bits): SDA released, shift in sda_i MSB first.
  - RNACK (1 bit): master releases SDA (NACK). rdata is loaded on entry to this state.
  - STOP (3 quarters):
    - q0: SCL low, SDA low.
    - q1: SCL released, SDA low.
    - q2: SCL released, SDA released.
  - DONE: one clock with done=1 and busy=0, then IDLE.
- Bit framing: every data or ack bit is 4 quarters.
  - q0, q1: SCL low. SDA is updated on the first clock of q0.
  - q2, q3: SCL released.
  - sda_i is sampled on the clock that ends q2.
- A transmitted 1 is SDA released; a transmitted 0 is sda_oe=1.
- No clock stretching and no arbitration: SCL is not read back.

## Timing
- Latency from the clock that accepts start to the done pulse:
  - ACKed transaction (read or write): 2+36+36+3 = 77 quarters, i.e. 77*CLK_DIV clocks, then done on the next clock.
  - Address NACK: 2+36+3 = 41 quarters, then done on the next clock.
- busy rises on the clock after acceptance and falls in the same clock that done rises.
- A new start is accepted in the cycle after done, at the earliest.
- SDA never changes while SCL is released, except the START q1 and STOP q2 edges.
- rdata and ack_err are valid in the done cycle and remain stable until the next accepted start. rdata is untouched by write transactions.
- rst_n asserted mid-transaction immediately releases SCL and SDA and forces all outputs to reset values. No STOP is generated. After rst_n deasserts the block is in IDLE.

## Test plan
- Write with slave ACK: CLK_DIV=4, addr=7'h50, rw=0, wdata=8'hA5.
  - Bus shows START, bits 8'hA0, ACK, bits 8'hA5, ACK, STOP.
  - done arrives 77*4+1 clocks after start; ack_err=0.
- Read: addr=7'h50, rw=1, slave drives 8'h3C.
  - rdata=8'h3C at done.
  - SDA is released in the 9th read bit (NACK), then STOP.
  - Write-path registers are unaffected.
- Address NACK: no slave responds (sda_i=1).
  - ack_err=1.
  - No data bits are clocked; STOP follows the address ack.
  - done arrives 41*CLK_DIV+1 clocks after start.
- Write data NACK: slave ACKs the address, NACKs the data byte.
  - ack_err=1, STOP issued, done after the full 77 quarters.
- start pulsed mid-transaction with different addr/wdata.
  - Ignored; the bus waveform matches the original request.
- rst_n low during the WRITE bit 3: scl_oe=0, sda_oe=0, busy=0 within the same cycle.
  - After release, a fresh write (addr=7'h12, wdata=8'h00) completes normally.
